// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS countdown timer: state and field codes,
// BCD digit width and a binary-to-packed-BCD helper for reset constants.
package timer_pkg;

  localparam int unsigned BCD_W          = 4;
  localparam int unsigned MAX_MIN_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_SETTING = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_BEEPING = 2'd3
  } state_e;

  typedef enum logic {
    FLD_MINUTES = 1'b0,
    FLD_TENSEC  = 1'b1
  } field_e;

  // Packed BCD of a binary value, digit 0 in the low nibble. Intended for
  // elaboration-time constants only (uses divide/modulo).
  function automatic logic [MAX_MIN_DIGITS*BCD_W-1:0] bin_to_bcd(input int unsigned bin);
    logic [MAX_MIN_DIGITS*BCD_W-1:0] res;
    int unsigned v;
    res = '0;
    v   = bin;
    for (int i = 0; i < MAX_MIN_DIGITS; i++) begin
      res[i*BCD_W +: BCD_W] = BCD_W'(v % 10);
      v = v / 10;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit. Load wins over decrement; decrementing from 0
// wraps to MAX_VAL and raises a combinational borrow for the next digit up.
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX_VAL = 4'd9,
  parameter logic [BCD_W-1:0] RST_VAL = 4'd0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [BCD_W-1:0] o_val,
  output logic             o_borrow
);

  logic [BCD_W-1:0] r_val;

  // Digit register: load, or decrement with wrap to MAX_VAL.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_val <= RST_VAL;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (i_dec) begin
      r_val <= (r_val == '0) ? MAX_VAL : r_val - 1'b1;
    end
  end

  assign o_val    = r_val;
  assign o_borrow = i_dec && (r_val == '0);

endmodule

// File: rtl/countdown_timer_core.sv
// MM:SS countdown engine with set / run / pause / alarm states.
// Optional feature macro: TIMER_ALARM_TIMEOUT_EN -- when defined, BEEPING
// returns to SETTING (with restore) after ALARM_SECS one-second ticks.
//
// Input contract: up, dn, field_sel, start_stop and cancel are single-cycle
// pulses from debouncers; each is acted on at the edge that samples it and
// its effect is visible on the registered outputs right after that edge.
module countdown_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned MIN_DIGITS    = 2,
  parameter int unsigned DEFAULT_MINS  = 1,
  parameter int unsigned ALARM_SECS    = 30
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        up,
  input  logic                        dn,
  input  logic                        field_sel,
  input  logic                        start_stop,
  input  logic                        cancel,
  output logic [3:0]                  secs,
  output logic [3:0]                  ten_secs,
  output logic [4*MIN_DIGITS-1:0]     mins,
  output logic [1:0]                  state,
  output logic                        field,
  output logic                        alarm_on,
  output logic                        colon
);

  localparam int unsigned MW = BCD_W * MIN_DIGITS;
  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [MAX_MIN_DIGITS*BCD_W-1:0] DEF_BCD_ALL = bin_to_bcd(DEFAULT_MINS);
  localparam logic [MW-1:0] DEF_MINS = DEF_BCD_ALL[MW-1:0];

  if (TICKS_PER_SEC < 2 || MIN_DIGITS < 1 || MIN_DIGITS > 3 || ALARM_SECS < 1) begin : g_bad_params
    $error("countdown_timer_core: illegal parameter set");
  end

  state_e           r_state, w_state_nxt;
  field_e           r_field;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic             r_alarm, r_colon, w_alarm_nxt, w_colon_nxt;
  logic [BCD_W-1:0] r_st_secs, r_st_ten;
  logic [MW-1:0]    r_st_mins;
  logic [BCD_W-1:0] w_secs, w_ten, w_ld_secs, w_ld_ten;
  logic [MW-1:0]    w_mins, w_ld_mins, w_mins_up, w_mins_dn;
  logic             w_tick, w_is_zero, w_is_one;
  logic             w_restore, w_capture, w_dec, w_edit, w_load;
  logic             w_secs_borrow, w_ten_borrow;
  logic [MIN_DIGITS-1:0] w_mborrow;
  logic             w_unused_borrow;

  assign w_tick    = (r_presc == PRE_LAST);
  assign w_is_zero = (w_secs == '0) && (w_ten == '0) && (w_mins == '0);
  assign w_is_one  = (w_secs == 4'd1) && (w_ten == '0) && (w_mins == '0);

`ifdef TIMER_ALARM_TIMEOUT_EN
  localparam int unsigned AW = $clog2(ALARM_SECS + 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);
  logic [AW-1:0] r_alarm_cnt;

  // Count one-second ticks spent in BEEPING; cleared whenever BEEPING is left or entered.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_alarm_cnt <= '0;
    end else if (r_state != ST_BEEPING || w_state_nxt != ST_BEEPING) begin
      r_alarm_cnt <= '0;
    end else if (w_tick) begin
      r_alarm_cnt <= r_alarm_cnt + 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_SETTING;
    else          r_state <= w_state_nxt;
  end

  // Next state and action strobes; cancel > start_stop > tick > edits.
  always_comb begin
    w_state_nxt = r_state;
    w_restore   = 1'b0;
    w_capture   = 1'b0;
    w_dec       = 1'b0;
    w_edit      = 1'b0;
    case (r_state)
      ST_SETTING: begin
        if (!cancel) begin
          if (start_stop) begin
            if (!w_is_zero) begin
              w_state_nxt = ST_RUNNING;
              w_capture   = 1'b1;
            end
          end else begin
            w_edit = 1'b1;
          end
        end
      end
      ST_RUNNING: begin
        if (cancel) begin
          w_state_nxt = ST_SETTING;
          w_restore   = 1'b1;
        end else if (start_stop) begin
          w_state_nxt = ST_PAUSED;
        end else if (w_tick) begin
          w_dec = 1'b1;
          if (w_is_one) w_state_nxt = ST_BEEPING;
        end
      end
      ST_PAUSED: begin
        if (cancel) begin
          w_state_nxt = ST_SETTING;
          w_restore   = 1'b1;
        end else if (start_stop) begin
          w_state_nxt = ST_RUNNING;
        end
      end
      ST_BEEPING: begin
        if (cancel || start_stop) begin
          w_state_nxt = ST_SETTING;
          w_restore   = 1'b1;
        end
`ifdef TIMER_ALARM_TIMEOUT_EN
        else if (w_tick && r_alarm_cnt == ALARM_LAST) begin
          w_state_nxt = ST_SETTING;
          w_restore   = 1'b1;
        end
`endif
      end
      default: w_state_nxt = ST_SETTING;
    endcase
  end

  // Modular BCD +1 / -1 of the minutes field; carry/borrow out of the top digit gives the wrap.
  always_comb begin
    logic v_carry, v_borrow;
    w_mins_up = w_mins;
    w_mins_dn = w_mins;
    v_carry   = 1'b1;
    v_borrow  = 1'b1;
    for (int d = 0; d < MIN_DIGITS; d++) begin
      if (v_carry) begin
        if (w_mins[d*BCD_W +: BCD_W] == 4'd9) begin
          w_mins_up[d*BCD_W +: BCD_W] = 4'd0;
        end else begin
          w_mins_up[d*BCD_W +: BCD_W] = w_mins[d*BCD_W +: BCD_W] + 4'd1;
          v_carry = 1'b0;
        end
      end
      if (v_borrow) begin
        if (w_mins[d*BCD_W +: BCD_W] == 4'd0) begin
          w_mins_dn[d*BCD_W +: BCD_W] = 4'd9;
        end else begin
          w_mins_dn[d*BCD_W +: BCD_W] = w_mins[d*BCD_W +: BCD_W] - 4'd1;
          v_borrow = 1'b0;
        end
      end
    end
  end

  // Digit load mux: restore the captured value, or apply a single-field edit (secs cleared).
  always_comb begin
    w_load    = 1'b0;
    w_ld_secs = w_secs;
    w_ld_ten  = w_ten;
    w_ld_mins = w_mins;
    if (w_restore) begin
      w_load    = 1'b1;
      w_ld_secs = r_st_secs;
      w_ld_ten  = r_st_ten;
      w_ld_mins = r_st_mins;
    end else if (w_edit && (up ^ dn)) begin
      w_load    = 1'b1;
      w_ld_secs = 4'd0;
      if (r_field == FLD_MINUTES) begin
        w_ld_mins = up ? w_mins_up : w_mins_dn;
      end else if (up) begin
        w_ld_ten = (w_ten == 4'd5) ? 4'd0 : w_ten + 4'd1;
      end else begin
        w_ld_ten = (w_ten == 4'd0) ? 4'd5 : w_ten - 4'd1;
      end
    end
  end

  // Prescaler: zero in SETTING, frozen in PAUSED and on a pausing pulse, free-running otherwise.
  always_comb begin
    w_presc_nxt = r_presc;
    if (w_state_nxt == ST_SETTING || r_state == ST_SETTING) begin
      w_presc_nxt = '0;
    end else if ((r_state == ST_RUNNING && !start_stop) || r_state == ST_BEEPING) begin
      w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
    end
  end

  // Output decode from next state so alarm_on and colon are registered with it.
  always_comb begin
    w_alarm_nxt = (w_state_nxt == ST_BEEPING);
    w_colon_nxt = 1'b1;
    if (w_state_nxt == ST_RUNNING || w_state_nxt == ST_BEEPING) begin
      w_colon_nxt = (w_presc_nxt < PRE_HALF);
    end
  end

  // Prescaler, field select, registered outputs and the restore snapshot.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_presc   <= '0;
      r_field   <= FLD_MINUTES;
      r_alarm   <= 1'b0;
      r_colon   <= 1'b1;
      r_st_secs <= '0;
      r_st_ten  <= '0;
      r_st_mins <= DEF_MINS;
    end else begin
      r_presc <= w_presc_nxt;
      r_alarm <= w_alarm_nxt;
      r_colon <= w_colon_nxt;
      if (w_edit && field_sel) begin
        r_field <= (r_field == FLD_MINUTES) ? FLD_TENSEC : FLD_MINUTES;
      end
      if (w_capture) begin
        r_st_secs <= w_secs;
        r_st_ten  <= w_ten;
        r_st_mins <= w_mins;
      end
    end
  end

  bcd_digit_down #(.MAX_VAL(4'd9), .RST_VAL(4'd0)) u_secs (
    .i_clk(CLK), .i_rst_n(RESET_N), .i_load(w_load), .i_load_val(w_ld_secs),
    .i_dec(w_dec), .o_val(w_secs), .o_borrow(w_secs_borrow)
  );

  bcd_digit_down #(.MAX_VAL(4'd5), .RST_VAL(4'd0)) u_ten (
    .i_clk(CLK), .i_rst_n(RESET_N), .i_load(w_load), .i_load_val(w_ld_ten),
    .i_dec(w_secs_borrow), .o_val(w_ten), .o_borrow(w_ten_borrow)
  );

  for (genvar gd = 0; gd < MIN_DIGITS; gd++) begin : g_min
    logic w_dig_dec;
    if (gd == 0) begin : g_first
      assign w_dig_dec = w_ten_borrow;
    end else begin : g_next
      assign w_dig_dec = w_mborrow[gd-1];
    end
    bcd_digit_down #(.MAX_VAL(4'd9), .RST_VAL(DEF_MINS[gd*BCD_W +: BCD_W])) u_min (
      .i_clk(CLK), .i_rst_n(RESET_N), .i_load(w_load), .i_load_val(w_ld_mins[gd*BCD_W +: BCD_W]),
      .i_dec(w_dig_dec), .o_val(w_mins[gd*BCD_W +: BCD_W]), .o_borrow(w_mborrow[gd])
    );
  end

  // The value never decrements below 00:00, so the top minute borrow is dead.
  assign w_unused_borrow = w_mborrow[MIN_DIGITS-1];

  assign secs     = w_secs;
  assign ten_secs = w_ten;
  assign mins     = w_mins;
  assign state    = r_state;
  assign field    = r_field;
  assign alarm_on = r_alarm;
  assign colon    = r_colon;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Testbench for countdown_timer_core (TICKS_PER_SEC=10, MIN_DIGITS=2,
// DEFAULT_MINS=1, ALARM_SECS=3). A seconds-based reference model predicts
// every cycle's outputs into exp_q; a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_countdown_timer_core;

  localparam int TPS = 10;
  localparam int MD  = 2;
  localparam int DEF = 1;
  localparam int AS  = 3;
  localparam int S_SET = 0, S_RUN = 1, S_PAU = 2, S_BEEP = 3;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       up = 1'b0, dn = 1'b0, field_sel = 1'b0, start_stop = 1'b0, cancel = 1'b0;
  logic [3:0] secs, ten_secs;
  logic [4*MD-1:0] mins;
  logic [1:0] state;
  logic       field, alarm_on, colon;

  countdown_timer_core #(
    .TICKS_PER_SEC(TPS), .MIN_DIGITS(MD), .DEFAULT_MINS(DEF), .ALARM_SECS(AS)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .up(up), .dn(dn), .field_sel(field_sel),
    .start_stop(start_stop), .cancel(cancel), .secs(secs), .ten_secs(ten_secs),
    .mins(mins), .state(state), .field(field), .alarm_on(alarm_on), .colon(colon)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  logic [20:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int m_state, m_field, m_total, m_store, m_presc, m_acnt;

  task automatic model_reset();
    m_state = S_SET; m_field = 0; m_total = DEF * 60; m_store = DEF * 60;
    m_presc = 0; m_acnt = 0;
  endtask

  task automatic model_restore();
    m_total = m_store; m_state = S_SET; m_presc = 0; m_acnt = 0;
  endtask

  task automatic model_edit(input bit inc);
    int m, t;
    m = m_total / 60;
    t = (m_total % 60) / 10;
    if (m_field == 0) m = inc ? (m + 1) % 100 : (m + 99) % 100;
    else              t = inc ? (t + 1) % 6   : (t + 5) % 6;
    m_total = m * 60 + t * 10;
  endtask

  task automatic model_step(input bit u, input bit d, input bit f, input bit s, input bit c);
    bit tick;
    tick = (m_presc == TPS - 1);
    case (m_state)
      S_SET: begin
        if (c) begin
        end else if (s) begin
          if (m_total != 0) begin m_store = m_total; m_state = S_RUN; m_presc = 0; end
        end else begin
          if (u != d) model_edit(u);
          if (f) m_field = 1 - m_field;
        end
      end
      S_RUN: begin
        if (c) model_restore();
        else if (s) m_state = S_PAU;
        else if (tick) begin
          m_total = m_total - 1; m_presc = 0;
          if (m_total == 0) begin m_state = S_BEEP; m_acnt = 0; end
        end else m_presc = m_presc + 1;
      end
      S_PAU: begin
        if (c) model_restore();
        else if (s) m_state = S_RUN;
      end
      default: begin
        if (c || s) model_restore();
        else if (tick) begin
          m_presc = 0;
`ifdef TIMER_ALARM_TIMEOUT_EN
          m_acnt = m_acnt + 1;
          if (m_acnt == AS) model_restore();
`endif
        end else m_presc = m_presc + 1;
      end
    endcase
  endtask

  function automatic logic [20:0] model_out();
    int m, s;
    logic c;
    m = m_total / 60;
    s = m_total % 60;
    c = (m_state == S_RUN || m_state == S_BEEP) ? (m_presc < TPS / 2) : 1'b1;
    return {2'(m_state), 1'(m_field), (m_state == S_BEEP), c,
            4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit u, input bit d, input bit f, input bit s, input bit c);
    @(negedge CLK);
    #1;
    up = u; dn = d; field_sel = f; start_stop = s; cancel = c;
    model_step(u, d, f, s, c);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 8'(state), 8'd0);
    check({tag, "_mins"}, mins, 8'h01);
    check({tag, "_ten"}, 8'(ten_secs), 8'd0);
    check({tag, "_secs"}, 8'(secs), 8'd0);
    check({tag, "_field"}, 8'(field), 8'd0);
    check({tag, "_alarm"}, 8'(alarm_on), 8'd0);
    check({tag, "_colon"}, 8'(colon), 8'd1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [20:0] exp, act;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {state, field, alarm_on, colon, mins, ten_secs, secs};
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t actual st=%0d fld=%0b al=%0b col=%0b %h:%h%h required st=%0d fld=%0b al=%0b col=%0b %h:%h%h",
                   $time, act[20:19], act[18], act[17], act[16], act[15:8], act[7:4], act[3:0],
                   exp[20:19], exp[18], exp[17], exp[16], exp[15:8], exp[7:4], exp[3:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    model_reset();
    #1 RESET_N = 1'b0;
    #3;
    check_reset_values("reset");
    repeat (3) @(negedge CLK);
    #1 RESET_N = 1'b1;

    // Full 60 s countdown from 01:00 into BEEPING, then acknowledge.
    cyc(0, 0, 0, 1, 0);
    idle(600);
    idle(20);
    cyc(0, 0, 0, 1, 0);
    // Second run left in BEEPING long enough for the optional timeout, then cancel.
    cyc(0, 0, 0, 1, 0);
    idle(640);
    cyc(0, 0, 0, 0, 1);

    // Edits: minute wrap 00 -> 99, ten-second wrap 5 -> 0.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0);

    // Back to minutes, 99 -> 10, run 10 s, pause 100 cycles, resume.
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(100);
    cyc(0, 0, 0, 1, 0);
    idle(100);
    cyc(0, 0, 0, 1, 0);
    idle(15);
    cyc(0, 0, 0, 0, 1);

    // 10:00 -> 01:00, run down to 00:37 and cancel on the tick edge.
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    guard = 0;
    while (!(m_state == S_RUN && m_total == 37 && m_presc == TPS - 1) && guard < 2000) begin
      cyc(0, 0, 0, 0, 0);
      guard++;
    end
    if (guard >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_align actual=timeout required=aligned");
    end
    cyc(0, 0, 0, 0, 1);
    idle(3);

    // Asynchronous reset mid-countdown.
    cyc(0, 0, 0, 1, 0);
    idle(25);
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check_reset_values("areset");
    model_reset();
    repeat (2) @(negedge CLK);
    #1 RESET_N = 1'b1;

    // Start at 00:00 is ignored; up+dn together changes nothing.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    idle(2);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Randomised pulse traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 79) == 0);
    end
    idle(2);

    // Drain the scoreboard.
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
